// File: rtl/ran_gen_range.sv
// Ranged random source: Fibonacci LFSR with seed load and lockup repair, serving
// draws in [0, limit) through a req/valid handshake using bounded rejection sampling.
module ran_gen_range #(
  parameter int unsigned        LFSR_W    = 48,
  parameter int unsigned        OUT_W     = 16,
  parameter int unsigned        OFFSET    = 16,
  parameter logic [LFSR_W-1:0]  TAPS      = 48'hAAAA_AAAA_AAAA,
  parameter logic [LFSR_W-1:0]  SEED      = 48'h0F0F_F0F0_0F0F,
  parameter int unsigned        MAX_TRIES = 15
) (
  input  logic              system_clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              run,
  input  logic              req,
  input  logic [OUT_W-1:0]  limit,
  output logic              busy,
  output logic              valid,
  output logic [OUT_W-1:0]  value,
  output logic              biased,
  output logic [OUT_W-1:0]  raw,
  output logic              lockup
);

  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [0:0] {StIdle, StDraw} state_e;

  state_e             fsm_q, fsm_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic               lockup_q, lockup_d;
  logic [OUT_W-1:0]   lim_q, lim_d;
  logic [OUT_W-1:0]   mask_q, mask_d;
  logic [TW-1:0]      tries_q, tries_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic               valid_q, valid_d;
  logic               biased_q, biased_d;

  logic               fb;
  logic               step;
  logic [OUT_W-1:0]   lim_m1;
  logic [OUT_W-1:0]   mask_new;
  logic [OUT_W-1:0]   cand;

  assign raw  = lfsr_q[OFFSET+OUT_W-1:OFFSET];
  assign busy = (fsm_q == StDraw);

  // LFSR next state: seed load beats lockup repair beats stepping.
  always_comb begin
    fb       = ^(lfsr_q & TAPS);
    step     = run | (fsm_q == StDraw);
    lfsr_d   = lfsr_q;
    lockup_d = 1'b0;
    if (seed_load) begin
      lfsr_d = (seed == '0) ? SEED : seed;
    end else if (lfsr_q == '0) begin
      lfsr_d   = SEED;
      lockup_d = 1'b1;
    end else if (step) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
    end
  end

  // Smear limit-1 downwards to get the smallest all-ones mask covering it.
  always_comb begin
    lim_m1 = limit - OUT_W'(1);
    for (int i = 0; i < OUT_W; i++) begin
      mask_new[i] = |(lim_m1 >> i);
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    lim_d    = lim_q;
    mask_d   = mask_q;
    tries_d  = tries_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    biased_d = 1'b0;
    cand     = raw & mask_q;
    case (fsm_q)
      StIdle: begin
        if (req) begin
          lim_d   = limit;
          mask_d  = mask_new;
          tries_d = '0;
          fsm_d   = StDraw;
        end
      end
      StDraw: begin
        if (lim_q == '0) begin
          value_d = raw;
          valid_d = 1'b1;
          fsm_d   = StIdle;
        end else if (lim_q == OUT_W'(1)) begin
          value_d = '0;
          valid_d = 1'b1;
          fsm_d   = StIdle;
        end else if (cand < lim_q) begin
          value_d = cand;
          valid_d = 1'b1;
          fsm_d   = StIdle;
        end else if (tries_q == TW'(MAX_TRIES - 1)) begin
          // Dropping the top mask bit guarantees a result below the limit.
          value_d  = cand & (mask_q >> 1);
          valid_d  = 1'b1;
          biased_d = 1'b1;
          fsm_d    = StIdle;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      fsm_q    <= StIdle;
      lfsr_q   <= SEED;
      lockup_q <= 1'b0;
      lim_q    <= '0;
      mask_q   <= '0;
      tries_q  <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      biased_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      lfsr_q   <= lfsr_d;
      lockup_q <= lockup_d;
      lim_q    <= lim_d;
      mask_q   <= mask_d;
      tries_q  <= tries_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      biased_q <= biased_d;
    end
  end

  assign valid  = valid_q;
  assign value  = value_q;
  assign biased = biased_q;
  assign lockup = lockup_q;

endmodule

// File: tb/tb_ran_gen_range.sv
// Scoreboard bench for ran_gen_range: directed draws queue expectations, a negedge
// monitor pops and compares on every valid; a TAPS=0 instance exercises lockup repair.
module tb_ran_gen_range;

  localparam logic [47:0] SEED = 48'h0F0F_F0F0_0F0F;
  localparam logic [47:0] TAPS = 48'hAAAA_AAAA_AAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_load = 1'b0;
  logic [47:0] seed = '0;
  logic        run = 1'b0;
  logic        req = 1'b0;
  logic [15:0] limit = '0;
  logic        busy, valid, biased, lockup;
  logic [15:0] value, raw;

  logic        seed_load_z = 1'b0;
  logic [47:0] seed_z = '0;
  logic        run_z = 1'b0;
  logic        req_z = 1'b0;
  logic [15:0] limit_z = '0;
  logic        busy_z, valid_z, biased_z, lockup_z;
  logic [15:0] value_z, raw_z;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ran_gen_range #(.MAX_TRIES(3)) dut (
    .system_clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .run(run),
    .req(req), .limit(limit), .busy(busy), .valid(valid), .value(value),
    .biased(biased), .raw(raw), .lockup(lockup)
  );

  ran_gen_range #(.TAPS(48'h0)) dut_z (
    .system_clk(clk), .rst(rst), .seed_load(seed_load_z), .seed(seed_z), .run(run_z),
    .req(req_z), .limit(limit_z), .busy(busy_z), .valid(valid_z), .value(value_z),
    .biased(biased_z), .raw(raw_z), .lockup(lockup_z)
  );

  typedef struct {
    logic [15:0] val;
    logic        bias;
    logic [15:0] lim;
    bit          exact;
    int          at;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulse req for one cycle and queue what the monitor should see.
  task automatic issue(input logic [15:0] l, input bit exact, input logic [15:0] v,
                       input logic b, input int lat);
    exp_t e;
    e.val   = v;
    e.bias  = b;
    e.lim   = l;
    e.exact = exact;
    e.at    = (lat < 0) ? -1 : cyc + lat;
    sb.push_back(e);
    limit = l;
    req   = 1'b1;
    tick();
    req   = 1'b0;
  endtask

  task automatic wait_valid(input int max_ticks, input string name);
    int n = 0;
    while (!valid && n < max_ticks) begin
      tick();
      n++;
    end
    checks++;
    if (!valid) begin
      failures++;
      $display("FAIL %s: valid=0 after %0d cycles, expected valid=1", name, max_ticks);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid value=%0h at cycle %0d, expected none",
                 value, cyc);
      end else begin
        e = sb.pop_front();
        if (e.exact) begin
          check("value", value, e.val);
          check("biased", biased, e.bias);
        end else begin
          check("in_range", (e.lim == 0) || (value < e.lim), 1);
          if (e.lim == 16'd1) check("limit1_zero", value, 0);
        end
        if (e.at >= 0) check("latency", cyc, e.at);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] m;
    int          n;
    do_reset();

    // Reset state and hold with run=0
    check("rst_raw", raw, 16'hF0F0);
    check("rst_state", dut.lfsr_q, SEED);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_biased", biased, 0);
    check("rst_value", value, 0);
    check("rst_lockup", lockup, 0);
    tick(); tick(); tick();
    check("hold_state", dut.lfsr_q, SEED);

    // Full range
    issue(16'h0000, 1, 16'hF0F0, 1'b0, 2);
    check("full_busy", busy, 1);
    wait_valid(3, "full_valid");
    tick();

    // Masked accept
    do_reset();
    issue(16'h0F00, 1, 16'h00F0, 1'b0, 2);
    check("mask_latch", dut.mask_q, 16'h0FFF);
    wait_valid(3, "mask_valid");
    tick();

    // limit=1 always yields 0
    issue(16'h0001, 1, 16'h0000, 1'b0, 2);
    wait_valid(3, "lim1_valid");
    tick();

    // Three rejections -> fallback 7 & 3
    seed_load = 1'b1; seed = 48'h0000_0007_C000;
    tick();
    seed_load = 1'b0;
    check("seed_loaded", dut.lfsr_q, 48'h0000_0007_C000);
    issue(16'd5, 1, 16'd3, 1'b1, 4);
    wait_valid(3, "fallback_valid");
    tick();

    // Reject 7, reject 6, accept 4
    seed_load = 1'b1; seed = 48'h0000_0007_0000;
    tick();
    seed_load = 1'b0;
    issue(16'd5, 1, 16'd4, 1'b0, 4);
    wait_valid(3, "retry_valid");
    tick();

    // Zero seed falls back to SEED
    seed_load = 1'b1; seed = '0;
    tick();
    seed_load = 1'b0;
    check("seed_zero", dut.lfsr_q, SEED);

    // Free-running sequence against XOR-of-odd-bits model
    m = SEED;
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      m = {m[46:0], ^(m & TAPS)};
      check("sequence", dut.lfsr_q, m);
    end

    // Back-to-back random limits, issued in the valid cycle
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] l;
      run = (i % 3 == 0);
      l = (i % 4 == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom_range(0, 65535));
      issue(l, 0, 16'h0, 1'b0, -1);
      wait_valid(3, "rand_valid");
    end
    tick();
    run = 1'b0;

    // Reset during DRAW aborts the draw
    seed_load = 1'b1; seed = 48'h0000_0007_C000;
    tick();
    seed_load = 1'b0;
    limit = 16'd5;
    req = 1'b1;
    tick();
    req = 1'b0;
    check("abort_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_idle", busy, 0);
    for (int i = 0; i < 5; i++) tick();
    check("abort_no_pending", sb.size(), 0);

    // Lockup: TAPS=0 shifts zeros in until the state clears
    run_z = 1'b1;
    n = 0;
    while (dut_z.lfsr_q != '0 && n < 60) begin
      tick();
      n++;
    end
    check("zero_after", n, 48);
    check("lockup_pre", lockup_z, 0);
    tick();
    check("lockup_pulse", lockup_z, 1);
    check("lockup_state", dut_z.lfsr_q, SEED);
    check("lockup_raw", raw_z, 16'hF0F0);
    tick();
    check("lockup_end", lockup_z, 0);
    check("z_quiet", {busy_z, valid_z, biased_z, value_z}, 0);
    run_z = 1'b0;

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ran_gen_range.md
# ran_gen_range

Parametrised successor to the game's free-running 48-bit LFSR random source. Holds a Fibonacci LFSR of configurable width and tap mask, with seed loading and all-zero lockup recovery. Serves draws in the range [0, limit) through a req/valid handshake, using bounded rejection sampling. Game FSMs use it for dice rolls, spawn positions and timers.

## Interface
- LFSR_W, default 48: LFSR state width (≥ OUT_W+OFFSET).
- OUT_W, default 16: output and limit width.
- OFFSET, default 16: LSB position of the raw output window in the state.
- TAPS, default 48'hAAAA_AAAA_AAAA: feedback mask. Feedback is the XOR of the state bits where TAPS=1.
- SEED, default 48'h0F0F_F0F0_0F0F: reset and fallback seed. Must be nonzero.
- MAX_TRIES, default 15: maximum number of rejection draws per request (≥1).

Ports (one clock; reset is synchronous and active-high):
- system_clk, in, 1: the only clock.
- rst, in, 1: synchronous, active-high reset.
- seed_load, in, 1: load `seed` into the state this cycle.
- seed, in, LFSR_W: new seed. A value of 0 is replaced by SEED.
- run, in, 1: advance the LFSR every cycle while high.
- req, in, 1: request one ranged draw. Sampled only in IDLE.
- limit, in, OUT_W: exclusive upper bound. 0 means the full range.
- busy, out, 1: high while in DRAW.
- valid, out, 1: one-cycle pulse; `value` is valid in that cycle.
- value, out, OUT_W: last ranged result. Held until the next valid.
- biased, out, 1: qualifies valid; the result came from the fallback path.
- raw, out, OUT_W: S[OFFSET+OUT_W-1:OFFSET]. Combinational from the state.
- lockup, out, 1: one-cycle pulse when an all-zero state is repaired.

## Operation
- **Step:** S <= {S[LFSR_W-2:0], fb}, where fb = ^(S & TAPS).
- **Advance condition:** the state steps when run=1 or the FSM is in DRAW. It steps at most once per cycle.
- **State-update priority:** rst > seed_load > lockup repair > step > hold.
  - Lockup repair: if S==0 and there is no seed_load, S <= SEED and lockup=1 in the next cycle.
- **Latches taken on req accept** (L = latched limit):
  - L <= limit.
  - mask <= smallest 2^k−1 ≥ L−1 (k ≥ 0).
  - tries <= 0.
- **FSM states:** IDLE, DRAW.
  - IDLE: when req=1, latch as above and go to DRAW. Otherwise stay.
  - DRAW: evaluate cand = raw & mask from the current S. The state steps in the same cycle.
    - L==0: value <= raw, valid, go to IDLE.
    - L==1: value <= 0, valid, go to IDLE.
    - cand < L: value <= cand, valid, biased=0, go to IDLE.
    - Otherwise, if tries == MAX_TRIES−1: value <= cand & (mask>>1), which is always < L. Assert valid and biased=1, go to IDLE.
    - Otherwise: tries++ and stay in DRAW.
- **req while busy:** ignored. It is not queued.
- **limit changes during DRAW:** no effect, because L is latched.
- **seed_load during DRAW:** the state is reloaded. The draw continues from the new state, and the current cycle's evaluation still uses the old S.
- **rst mid-draw:** abort immediately. No valid is produced.
- **Reset values:** S=SEED, IDLE, busy=0, valid=0, biased=0, value=0, lockup=0, tries=0, L=0, mask=0.

## Timing
- All outputs are registered except raw and busy. busy is decoded from the FSM state.
- req accepted in cycle t:
  - DRAW runs from t+1.
  - Minimum latency: valid in cycle t+2.
  - Maximum latency: valid in cycle t+1+MAX_TRIES.
- In the valid cycle the FSM is already in IDLE. A req in that cycle is accepted, so back-to-back draws run at one result every 2 cycles minimum.
- seed_load in cycle t: S equals the loaded seed in cycle t+1.
- lockup: S==0 in cycle t gives S=SEED and lockup=1 in cycle t+1.

## Test plan
- **Reset state:** rst, then idle with run=0 → raw=0xF0F0, S=SEED, all outputs 0, S held constant.
- **Full range:** after reset (run=0), req with limit=0 at cycle t → busy in t+1, valid in t+2 with value=0xF0F0, biased=0.
- **Masked accept:** after reset (run=0), req with limit=0x0F00 → mask=0x0FFF, cand=0x00F0, valid in t+2 with value=0x00F0.
- **Rejection and fallback:**
  - Use MAX_TRIES=3, seed chosen so that three consecutive candidates ≥ L (e.g. L=5, mask=7).
  - Expect valid at t+4, biased=1, value<4.
  - Check that every run of 10k random limits yields value<limit, and that limit=1 always gives 0.
- **Seed and lockup:**
  - seed_load with seed=0 → S=SEED next cycle.
  - Force S=0 by a bench override with TAPS=0 → lockup pulse, and S=SEED the following cycle.
- **Sequence and abort:**
  - run=1 for 100 cycles; S matches a software XOR-of-odd-bits model on every cycle.
  - rst asserted during DRAW → no valid, FSM in IDLE next cycle.
